// File: rtl/sys_array_ctrl_if.sv
// Job-request and array-sequencing signals between the buffer front end (master)
// and the systolic-array sequencer (slave).
interface sys_array_ctrl_if #(
    parameter int ARRAY_H      = 4,
    parameter int ARRAY_W      = 4,
    parameter int VEC_ADDR_W   = 8,
    parameter int PARAM_ADDR_W = 2
);
    logic                    start;
    logic                    skip_load;
    logic [VEC_ADDR_W-1:0]   num_vectors;
    logic                    busy;
    logic                    done;
    logic                    param_load;
    logic [PARAM_ADDR_W-1:0] param_rd_addr;
    logic                    in_rd_en;
    logic [VEC_ADDR_W-1:0]   in_rd_addr;
    logic [ARRAY_H-1:0]      row_en;
    logic [ARRAY_W-1:0]      col_valid;

    modport master (
        output start, skip_load, num_vectors,
        input  busy, done, param_load, param_rd_addr, in_rd_en, in_rd_addr, row_en, col_valid
    );

    modport slave (
        input  start, skip_load, num_vectors,
        output busy, done, param_load, param_rd_addr, in_rd_en, in_rd_addr, row_en, col_valid
    );
endinterface

// File: rtl/sys_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads the parameter chain,
// streams input vectors with diagonal row skew and flags results leaving each column.
module sys_array_ctrl #(
    parameter int ARRAY_H      = 4,
    parameter int ARRAY_W      = 4,
    parameter int VEC_ADDR_W   = 8,
    parameter int PARAM_ADDR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    sys_array_ctrl_if.slave  bus
);
    localparam int CHAIN_W = ARRAY_H + ARRAY_W;
    localparam int DRAIN_W = $clog2(CHAIN_W);
    localparam logic [DRAIN_W-1:0]      DRAIN_LAST = DRAIN_W'(CHAIN_W - 2);
    localparam logic [PARAM_ADDR_W-1:0] PARAM_TOP  = PARAM_ADDR_W'(ARRAY_H - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                  state_q;
    logic [VEC_ADDR_W-1:0]   n_q;
    logic [VEC_ADDR_W-1:0]   in_rd_addr_q;
    logic [DRAIN_W-1:0]      drain_q;
    logic [PARAM_ADDR_W-1:0] param_rd_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    param_load_q;
    logic                    in_rd_en_q;
    logic [CHAIN_W-2:0]      skew_q;
    logic [CHAIN_W-1:0]      chain_s;

    // Job sequencer; every output is registered against the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            n_q             <= '0;
            in_rd_addr_q    <= '0;
            drain_q         <= '0;
            param_rd_addr_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            param_load_q    <= 1'b0;
            in_rd_en_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        n_q          <= bus.num_vectors;
                        in_rd_addr_q <= '0;
                        if (!bus.skip_load) begin
                            state_q         <= S_LOAD;
                            busy_q          <= 1'b1;
                            param_load_q    <= 1'b1;
                            param_rd_addr_q <= PARAM_TOP;
                        end else if (bus.num_vectors == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_STREAM;
                            busy_q     <= 1'b1;
                            in_rd_en_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Bottom row is pushed first so row r ends up holding parameter row r.
                    if (param_rd_addr_q == '0) begin
                        param_load_q <= 1'b0;
                        if (n_q == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_STREAM;
                            in_rd_en_q <= 1'b1;
                        end
                    end else begin
                        param_rd_addr_q <= param_rd_addr_q - PARAM_ADDR_W'(1);
                    end
                end
                S_STREAM: begin
                    if (in_rd_addr_q == n_q - VEC_ADDR_W'(1)) begin
                        state_q    <= S_DRAIN;
                        in_rd_en_q <= 1'b0;
                        drain_q    <= DRAIN_LAST;
                    end else begin
                        in_rd_addr_q <= in_rd_addr_q + VEC_ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    param_load_q <= 1'b0;
                    in_rd_en_q   <= 1'b0;
                end
            endcase
        end
    end

    // Skew chain: tap k is in_rd_en delayed k cycles, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            skew_q <= '0;
        end else begin
            skew_q[0] <= in_rd_en_q;
            for (int k = 1; k < CHAIN_W - 1; k++) begin
                skew_q[k] <= skew_q[k-1];
            end
        end
    end

    assign chain_s           = {skew_q, in_rd_en_q};
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.param_load    = param_load_q;
    assign bus.param_rd_addr = param_rd_addr_q;
    assign bus.in_rd_en      = in_rd_en_q;
    assign bus.in_rd_addr    = in_rd_addr_q;
    assign bus.row_en        = chain_s[ARRAY_H-1:0];
    assign bus.col_valid     = chain_s[CHAIN_W-1:ARRAY_H];
endmodule

// File: tb/tb_sys_array_ctrl.sv
// Self-checking bench for sys_array_ctrl: table of job scenarios with expected
// summary figures, plus per-cycle comparison against an interval-based model.
module tb_sys_array_ctrl;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int VA = 8;
    localparam int PA = 2;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          param_load;
        logic [PA-1:0] pra;
        logic          in_rd_en;
        logic [VA-1:0] ira;
        logic [H-1:0]  row_en;
        logic [W-1:0]  col;
    } out_t;

    typedef struct {
        int skip;
        int n;
        int mode;
        int exp_busy;
        int exp_dones;
        int exp_done_k;
        int exp_first_rd;
        int exp_loads;
        int exp_col3;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sys_array_ctrl_if #(.ARRAY_H(H), .ARRAY_W(W), .VEC_ADDR_W(VA), .PARAM_ADDR_W(PA)) bus ();

    sys_array_ctrl #(.ARRAY_H(H), .ARRAY_W(W), .VEC_ADDR_W(VA), .PARAM_ADDR_W(PA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic out_t sample();
        out_t o;
        o.busy       = bus.busy;
        o.done       = bus.done;
        o.param_load = bus.param_load;
        o.pra        = bus.param_rd_addr;
        o.in_rd_en   = bus.in_rd_en;
        o.ira        = bus.in_rd_addr;
        o.row_en     = bus.row_en;
        o.col        = bus.col_valid;
        return o;
    endfunction

    // Expected outputs k cycles after the start edge, from the job's activity windows.
    function automatic out_t model(int k, int skip, int n);
        out_t o;
        int   l;
        int   t0;
        int   total;
        o     = '0;
        l     = (skip != 0) ? 0 : H;
        t0    = l + 1;
        total = (n == 0) ? l : l + n + H + W - 1;
        o.busy = (k >= 1 && k <= total);
        o.done = (k == total + 1);
        if (k <= l) begin
            o.param_load = 1'b1;
            o.pra        = PA'(H - k);
        end
        o.in_rd_en = (k >= t0 && k < t0 + n);
        if (n == 0 || k < t0)  o.ira = '0;
        else if (k < t0 + n)   o.ira = VA'(k - t0);
        else                   o.ira = VA'(n - 1);
        for (int i = 0; i < H; i++) o.row_en[i] = (k >= t0 + i && k < t0 + i + n);
        for (int j = 0; j < W; j++) o.col[j] = (k >= t0 + H + j && k < t0 + H + j + n);
        return o;
    endfunction

    task automatic check_out(input string name, input int k, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one job from a negedge; mode 1 = stray starts and num_vectors change,
    // mode 2 = reset at cycle 6, mode 3 = num_vectors scrambled while busy.
    task automatic run_job(input int skip, input int n, input int mode,
                           output int busy_cnt, output int done_cnt, output int done_k,
                           output int first_rd, output int loads, output int col3);
        out_t act;
        out_t exp;
        int   l;
        int   t0;
        int   total;
        int   kmax;
        l        = (skip != 0) ? 0 : H;
        t0       = l + 1;
        total    = (n == 0) ? l : l + n + H + W - 1;
        kmax     = (mode == 2) ? 12 : total + 4;
        busy_cnt = 0; done_cnt = 0; done_k = 0; first_rd = 0; loads = 0; col3 = 0;
        bus.start       = 1'b1;
        bus.skip_load   = (skip != 0);
        bus.num_vectors = VA'(n);
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            act = sample();
            exp = (mode == 2 && k >= 7) ? '0 : model(k, skip, n);
            if (!exp.param_load && !(mode == 2 && k >= 7)) act.pra = '0;
            check_out("cycle", k, act, exp);
            busy_cnt += int'(act.busy);
            loads    += int'(act.param_load);
            col3     += int'(act.col[W-1]);
            if (act.done) begin
                done_cnt++;
                done_k = k;
            end
            if (act.in_rd_en && first_rd == 0) first_rd = k;
            if (mode == 1) begin
                bus.start = (k == t0 + 1 || k == total + 1);
                if (k == t0 + 1) bus.num_vectors = VA'(9);
            end
            if (mode == 2) reset = (k == 6);
            if (mode == 3) bus.num_vectors = VA'($urandom);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    vec_t vecs[9];
    out_t rst_act;
    int   bc, dc, dk, fr, ld, c3;

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.skip_load   = 1'b0;
        bus.num_vectors = '0;

        //            skip  n  mode busy dones done_k first loads col3
        vecs[0] = '{0,   3,  0,  14,  1,  15,  5,  4,   3};
        vecs[1] = '{1,   3,  0,  10,  1,  11,  1,  0,   3};
        vecs[2] = '{0,   0,  0,   4,  1,   5,  0,  4,   0};
        vecs[3] = '{1,   0,  0,   0,  1,   1,  0,  0,   0};
        vecs[4] = '{0,   1,  0,  12,  1,  13,  5,  4,   1};
        vecs[5] = '{0,   3,  1,  14,  1,  15,  5,  4,   3};
        vecs[6] = '{0,   3,  2,   6,  0,   0,  5,  4,   0};
        vecs[7] = '{0,   3,  0,  14,  1,  15,  5,  4,   3};
        vecs[8] = '{1, 255,  0, 262,  1, 263,  1,  0, 255};

        repeat (3) @(negedge clk);
        rst_act = sample();
        check_out("reset_state", 0, rst_act, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_job(vecs[v].skip, vecs[v].n, vecs[v].mode, bc, dc, dk, fr, ld, c3);
            check_int($sformatf("v%0d_busy_cycles", v), bc, vecs[v].exp_busy);
            check_int($sformatf("v%0d_done_count", v), dc, vecs[v].exp_dones);
            check_int($sformatf("v%0d_done_cycle", v), dk, vecs[v].exp_done_k);
            check_int($sformatf("v%0d_first_read", v), fr, vecs[v].exp_first_rd);
            check_int($sformatf("v%0d_param_loads", v), ld, vecs[v].exp_loads);
            check_int($sformatf("v%0d_col3_pulses", v), c3, vecs[v].exp_col3);
        end

        for (int r = 0; r < 25; r++) begin
            int skip_r;
            int n_r;
            int mode_r;
            skip_r = int'($urandom_range(0, 1));
            n_r    = int'($urandom_range(0, 40));
            mode_r = (int'($urandom_range(0, 1)) == 1) ? 3 : 0;
            run_job(skip_r, n_r, mode_r, bc, dc, dk, fr, ld, c3);
            check_int($sformatf("rand%0d_done_count", r), dc, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
